wide_add_ctrl: RTL and testbench
================================

Name: wide_add_ctrl

Overview:
- Sequencer that performs a multi-word (WORDS x 16-bit) add or subtract by time-sharing one internal 16-bit ripple-carry adder.
- The adder is driven over WORDS cycles, least-significant word first, with the carry held in a flop between words.
- Sits between the switch/Run front end and the result registers. Gives wide arithmetic without replicating adder hardware.

Parameters:
WORDS, 4, number of 16-bit words per operand; legal range 1..8; operand width W = 16*WORDS

Ports:
Clk     input   1   system clock, all state updates on rising edge
Reset   input   1   synchronous, active-high reset
Run     input   1   start request, level; sampled only in IDLE
Sub     input   1   0 = A+B, 1 = A-B; latched with the operands
A       input   W   operand A
B       input   W   operand B
S       output  W   result; registered
Cout    output  1   final carry out; for Sub, 1 = no borrow
Busy    output  1   high while in CALC
Done    output  1   one-cycle completion pulse

Behaviour:
- Reset (synchronous, Reset=1 at rising edge): state=IDLE; S=0, Cout=0, Busy=0, Done=0; internal operand regs, word index and carry flop cleared. Reset overrides all other inputs, including mid-CALC: the partial result is discarded and no Done is issued.
- Datapath per word i:
  - Adder inputs are A_reg[16i+15:16i] and B_reg[16i+15:16i] XOR {16{Sub_reg}}, with cin = carry flop.
  - The sum word goes to a partial-result register; carry flop <= adder cout.
- FSM states: IDLE, CALC, DONE, HOLD.
- IDLE:
  - Busy=0, Done=0.
  - If Run=1 at an edge: latch A, B, Sub into A_reg, B_reg, Sub_reg; idx<=0; carry<=Sub; go to CALC.
- CALC:
  - Busy=1. Each edge processes word idx, then idx<=idx+1.
  - After the edge that processes word WORDS-1: S <= full partial result (atomic update, so S never shows a half-computed value) and Cout <= final carry; go to DONE.
  - A, B, Sub and Run are ignored during CALC.
- DONE:
  - Done=1 for exactly one cycle; Busy=0.
  - Next state is HOLD if Run=1, else IDLE.
- HOLD:
  - Done=0. Stay while Run=1; go to IDLE when Run=0.
  - Holding Run high therefore gives exactly one operation.
- Latency: Run sampled at edge k; Busy high for cycles k+1..k+WORDS; S/Cout valid and Done=1 in the cycle after edge k+WORDS.
  - WORDS=1 gives one CALC cycle.
  - Minimum restart: Run re-sampled in IDLE two cycles after the DONE cycle (DONE -> IDLE -> sample).
- S and Cout hold their last value until the next completed operation or Reset.
- Arithmetic is modulo 2^W: no saturation, no sign extension; Cout is the carry out of bit W-1.

Optional Feature:
- Macro: WIDE_ADD_OVF_EN
- Defined:
  - Adds output port V (1 bit, registered, reset 0), updated at the same edge as S.
  - V = signed two's-complement overflow = (A_reg[W-1] ~^ Bx[W-1]) & (S[W-1] ^ A_reg[W-1]), where Bx is B_reg after the Sub inversion.
- Undefined: port V and its logic are absent; all other behaviour is identical.

Test Plan:
- WORDS=4, A=0x0000_0000_FFFF_FFFF, B=0x1, Sub=0, Run pulse -> Busy high for 4 cycles; then S=0x0000_0001_0000_0000, Cout=0, Done=1 for one cycle.
- A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, Sub=0 -> S=0, Cout=1 (carry ripples through all 4 words).
- Sub=1, A=0x5, B=0x7 -> S=0xFFFF_FFFF_FFFF_FFFE, Cout=0. Then A=0x7, B=0x5 -> S=0x2, Cout=1.
- Operand and Run timing:
  - Run held high 20 cycles, with A/B changed during CALC -> exactly one Done pulse, result computed from the operands latched at start.
  - Second op starts only after Run drops and is re-asserted.
- Reset=1 on the 2nd CALC cycle of A=B=0xFFFF_FFFF_FFFF_FFFF -> next cycle S=0, Cout=0, Busy=0, no Done ever pulses; a following Run with A=1, B=2 gives S=3.
- With WIDE_ADD_OVF_EN defined: A=0x7FFF_FFFF_FFFF_FFFF, B=0x1, Sub=0 -> S=0x8000_0000_0000_0000, V=1, Cout=0. Then A=0x1, B=0x2 -> V=0.

Source files
------------

// File: rtl/wide_add_ctrl.sv
// wide_add_ctrl: multi-word add/subtract sequencer.
//   One 16-bit adder is time-shared over WORDS cycles, least-significant word
//   first. The carry between words is kept in a flop. The result register
//   updates once, after the last word, so S never shows a half-computed sum.
//
// Ports:
//   Clk    - clock; all state changes on the rising edge
//   Reset  - synchronous, active-high reset
//   Run    - start request (level); sampled only in IDLE
//   Sub    - 0: A+B, 1: A-B; latched together with the operands
//   A, B   - operands, 16*WORDS bits wide
//   S      - registered result (modulo 2^W)
//   Cout   - registered carry out of bit W-1 (for Sub, 1 = no borrow)
//   V      - registered signed overflow (only when WIDE_ADD_OVF_EN is defined)
//   Busy   - high while words are being processed
//   Done   - one-cycle completion pulse
//
// Optional feature macro: WIDE_ADD_OVF_EN adds the V output.
module wide_add_ctrl #(
  parameter int WORDS = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Run,
  input  logic                  Sub,
  input  logic [16*WORDS-1:0]   A,
  input  logic [16*WORDS-1:0]   B,
  output logic [16*WORDS-1:0]   S,
  output logic                  Cout,
`ifdef WIDE_ADD_OVF_EN
  output logic                  V,
`endif
  output logic                  Busy,
  output logic                  Done
);

  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [WORDS-1:0][15:0]  a_q, a_d;
  logic [WORDS-1:0][15:0]  b_q, b_d;
  logic                    sub_q, sub_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic                    carry_q, carry_d;
  logic [WORDS-1:0][15:0]  part_q, part_d;
  logic [WORDS-1:0][15:0]  s_q, s_d;
  logic                    cout_q, cout_d;
`ifdef WIDE_ADD_OVF_EN
  logic                    v_q, v_d;
`endif

  // Shared adder and the partial result with the current word merged in.
  logic [15:0]             a_word, bx_word;
  logic [16:0]             sum;
  logic [WORDS-1:0][15:0]  res_full;

  always_comb begin
    a_word   = a_q[idx_q];
    // Subtraction is A + ~B + 1; the +1 enters as the initial carry.
    bx_word  = b_q[idx_q] ^ {16{sub_q}};
    sum      = {1'b0, a_word} + {1'b0, bx_word} + {16'b0, carry_q};
    res_full = part_q;
    res_full[idx_q] = sum[15:0];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    part_d  = part_q;
    s_d     = s_q;
    cout_d  = cout_q;
`ifdef WIDE_ADD_OVF_EN
    v_d     = v_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (Run) begin
          a_d     = A;
          b_d     = B;
          sub_d   = Sub;
          idx_d   = '0;
          carry_d = Sub;
          state_d = CALC;
        end
      end
      CALC: begin
        part_d  = res_full;
        carry_d = sum[16];
        if (idx_q == LAST) begin
          idx_d   = '0;
          s_d     = res_full;
          cout_d  = sum[16];
`ifdef WIDE_ADD_OVF_EN
          // Operand signs agree but result sign differs from A.
          v_d     = (a_q[WORDS-1][15] ~^ (b_q[WORDS-1][15] ^ sub_q)) &
                    (res_full[WORDS-1][15] ^ a_q[WORDS-1][15]);
`endif
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: state_d = Run ? HOLD : IDLE;
      // Waiting for Run to drop so a held Run yields only one operation.
      HOLD: if (!Run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      part_q  <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
`ifdef WIDE_ADD_OVF_EN
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      part_q  <= part_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
`ifdef WIDE_ADD_OVF_EN
      v_q     <= v_d;
`endif
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;
`ifdef WIDE_ADD_OVF_EN
  assign V    = v_q;
`endif
  assign Busy = (state_q == CALC);
  assign Done = (state_q == DONE);

endmodule

// File: tb/tb_wide_add_ctrl.sv
module tb_wide_add_ctrl;
  localparam int WORDS = 4;
  localparam int W = 16 * WORDS;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Run = 1'b0;
  logic          Sub = 1'b0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic [W-1:0]  S;
  logic          Cout, Busy, Done;
`ifdef WIDE_ADD_OVF_EN
  logic          V;
`endif

  wide_add_ctrl #(.WORDS(WORDS)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Sub(Sub), .A(A), .B(B),
    .S(S), .Cout(Cout),
`ifdef WIDE_ADD_OVF_EN
    .V(V),
`endif
    .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  always @(negedge Clk) if (Done === 1'b1) done_cnt++;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: plain W-bit arithmetic. Cout for subtraction is "no borrow".
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W:0] wide;
    logic [W:0] sgn;
    logic       c, v;
    if (sub) begin
      wide = {1'b0, a - b};
      c    = (a >= b);
      sgn  = {a[W-1], a} - {b[W-1], b};
    end else begin
      wide = {1'b0, a} + {1'b0, b};
      c    = wide[W];
      sgn  = {a[W-1], a} + {b[W-1], b};
    end
    v = sgn[W] ^ sgn[W-1];
    return {v, c, wide[W-1:0]};
  endfunction

  // Start one op, scramble inputs during CALC, then check timing and result.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic [W-1:0] es, input logic ec, input logic ev);
    int busy_n = 0;
    int cyc = 0;
    @(negedge Clk);
    A = a; B = b; Sub = sub; Run = 1'b1;
    @(negedge Clk);
    Run = 1'b0; A = ~a; B = $urandom; Sub = ~sub;
    while (Done !== 1'b1 && cyc < 20) begin
      if (Busy === 1'b1) busy_n++;
      cyc++;
      @(negedge Clk);
    end
    chk({name, ".done_seen"}, W'(Done), W'(1));
    chk({name, ".busy_cycles"}, W'(busy_n), W'(WORDS));
    chk({name, ".S"}, S, es);
    chk({name, ".Cout"}, W'(Cout), W'(ec));
`ifdef WIDE_ADD_OVF_EN
    chk({name, ".V"}, W'(V), W'(ev));
`else
    if (ev === 1'bx) $display("note: undefined expected V");
`endif
    @(negedge Clk);
    chk({name, ".done_1cyc"}, W'(Done), W'(0));
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [W-1:0] ra, rb, hs;
    logic         rsub;
    logic [W+1:0] m;
    int           d0;

    vecs[0] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[2] = '{64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[3] = '{64'h7, 64'h5, 1'b1, 64'h2, 1'b1, 1'b0};
    vecs[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[5] = '{64'h1, 64'h2, 1'b0, 64'h3, 1'b0, 1'b0};
    vecs[6] = '{64'h0, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
    vecs[7] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[8] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 64'h0001_0000_0001_0000, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(negedge Clk);
    chk("rst.S", S, '0);
    chk("rst.Cout", W'(Cout), '0);
    chk("rst.Busy", W'(Busy), '0);
    chk("rst.Done", W'(Done), '0);
`ifdef WIDE_ADD_OVF_EN
    chk("rst.V", W'(V), '0);
`endif
    Reset = 1'b0;

    for (int i = 0; i < 9; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].s, vecs[i].c, vecs[i].v);

    // Run held high for 20 cycles with operands changing: exactly one op.
    d0 = done_cnt;
    @(negedge Clk);
    A = 64'h1234_5678_9ABC_DEF0; B = 64'h0FED_CBA9_8765_4321; Sub = 1'b1; Run = 1'b1;
    m = model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      A = {$urandom, $urandom}; B = {$urandom, $urandom}; Sub = $urandom_range(0, 1);
    end
    chk("hold.done_pulses", W'(done_cnt - d0), W'(1));
    chk("hold.S", S, m[W-1:0]);
    chk("hold.Cout", W'(Cout), W'(m[W]));
    chk("hold.Busy", W'(Busy), '0);
    Run = 1'b0;
    @(negedge Clk);
    chk("hold.no_restart", W'(Busy), '0);
    run_op("after_hold", 64'h10, 64'h20, 1'b0, 64'h30, 1'b0, 1'b0);

    // Reset during the second CALC cycle discards the operation.
    hs = S;
    d0 = done_cnt;
    @(negedge Clk);
    A = '1; B = '1; Sub = 1'b0; Run = 1'b1;
    @(negedge Clk);
    Run = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("midrst.prev_S_nonzero", W'(hs != '0), W'(1));
    chk("midrst.S", S, '0);
    chk("midrst.Cout", W'(Cout), '0);
    chk("midrst.Busy", W'(Busy), '0);
    repeat (8) @(negedge Clk);
    chk("midrst.no_done", W'(done_cnt - d0), '0);
    run_op("post_rst", 64'h1, 64'h2, 1'b0, 64'h3, 1'b0, 1'b0);

    // Randomized ops against the model.
    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 8 == 1) rb = ~ra;
      if (i % 8 == 2) rb = ra;
      if (i % 8 == 3) ra = {16'h7FFF, ra[47:0]};
      rsub = $urandom_range(0, 1);
      m = model(ra, rb, rsub);
      run_op($sformatf("rnd%0d", i), ra, rb, rsub, m[W-1:0], m[W], m[W+1]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
